// File: rtl/dma_rd_desc_arb_if.sv
// DMA read descriptor stream bundle.
// Carries one descriptor (host address, RAM address, length, tag) with a
// valid/ready handshake. The tag width is set per instance, so the same
// bundle serves the source channels (source tag only) and the merged
// channel (source bit + source tag).
//   master : drives the descriptor fields and valid, samples ready
//   slave  : samples the descriptor fields and valid, drives ready
interface dma_rd_desc_arb_if #(
    parameter int DMA_ADDR_WIDTH = 64,
    parameter int RAM_ADDR_WIDTH = 15,
    parameter int DMA_LEN_WIDTH  = 16,
    parameter int TAG_WIDTH      = 7
);
    logic [DMA_ADDR_WIDTH-1:0] dma_addr;
    logic [RAM_ADDR_WIDTH-1:0] ram_addr;
    logic [DMA_LEN_WIDTH-1:0]  len;
    logic [TAG_WIDTH-1:0]      tag;
    logic                      valid;
    logic                      ready;

    modport master (output dma_addr, ram_addr, len, tag, valid, input ready);
    modport slave  (input dma_addr, ram_addr, len, tag, valid, output ready);
endinterface

// File: rtl/dma_rd_desc_arb.sv
// Two-source DMA read descriptor arbiter (CU = source 0, RE = source 1).
// Round-robin arbitration onto one registered descriptor channel. Each
// granted descriptor is stamped with its source bit, which is also exported
// on the wqe_tag stream for the downstream write-data demux. Completion
// status is routed back to the issuing source by the tag MSB, and each
// source is limited to MAX_OUTSTANDING descriptors in flight.
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   s_axis_cu_rd_desc              CU descriptor input (slave)
//   s_axis_re_rd_desc              RE descriptor input (slave)
//   m_axis_dma_read_desc           merged descriptor output (master)
//   m_axis_dma_read_wqe_*          source-bit stream mirroring the output
//   s_axis_dma_read_desc_status_*  completion status input, no backpressure
//   m_axis_{cu,re}_rd_desc_status_* per-source completion outputs
//   cu_outstanding, re_outstanding in-flight counts
//   status_underflow               sticky: completion for an idle source
module dma_rd_desc_arb #(
    parameter int DMA_ADDR_WIDTH  = 64,
    parameter int RAM_ADDR_WIDTH  = 15,
    parameter int DMA_LEN_WIDTH   = 16,
    parameter int SRC_TAG_WIDTH   = 7,
    parameter int DMA_TAG_WIDTH   = SRC_TAG_WIDTH + 1,
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    dma_rd_desc_arb_if.slave         s_axis_cu_rd_desc,
    dma_rd_desc_arb_if.slave         s_axis_re_rd_desc,
    dma_rd_desc_arb_if.master        m_axis_dma_read_desc,
    output logic                     m_axis_dma_read_wqe_tag,
    output logic                     m_axis_dma_read_wqe_valid,
    output logic                     m_axis_dma_read_wqe_ready,
    input  logic [DMA_TAG_WIDTH-1:0] s_axis_dma_read_desc_status_tag,
    input  logic [3:0]               s_axis_dma_read_desc_status_error,
    input  logic                     s_axis_dma_read_desc_status_valid,
    output logic [SRC_TAG_WIDTH-1:0] m_axis_cu_rd_desc_status_tag,
    output logic [3:0]               m_axis_cu_rd_desc_status_error,
    output logic                     m_axis_cu_rd_desc_status_valid,
    output logic [SRC_TAG_WIDTH-1:0] m_axis_re_rd_desc_status_tag,
    output logic [3:0]               m_axis_re_rd_desc_status_error,
    output logic                     m_axis_re_rd_desc_status_valid,
    output logic [7:0]               cu_outstanding,
    output logic [7:0]               re_outstanding,
    output logic                     status_underflow
);
    localparam logic [7:0] MAX_CNT = 8'(MAX_OUTSTANDING);

    // last_re_q = 1 means RE won the last grant, so CU is favoured next.
    logic                      last_re_q, last_re_d;
    logic                      m_valid_q, m_valid_d;
    logic                      m_src_q, m_src_d;
    logic [DMA_ADDR_WIDTH-1:0] m_dma_addr_q, m_dma_addr_d;
    logic [RAM_ADDR_WIDTH-1:0] m_ram_addr_q, m_ram_addr_d;
    logic [DMA_LEN_WIDTH-1:0]  m_len_q, m_len_d;
    logic [SRC_TAG_WIDTH-1:0]  m_src_tag_q, m_src_tag_d;
    logic [7:0]                cu_cnt_q, cu_cnt_d;
    logic [7:0]                re_cnt_q, re_cnt_d;
    logic                      underflow_q, underflow_d;
    logic                      cu_st_valid_q, cu_st_valid_d;
    logic [SRC_TAG_WIDTH-1:0]  cu_st_tag_q, cu_st_tag_d;
    logic [3:0]                cu_st_err_q, cu_st_err_d;
    logic                      re_st_valid_q, re_st_valid_d;
    logic [SRC_TAG_WIDTH-1:0]  re_st_tag_q, re_st_tag_d;
    logic [3:0]                re_st_err_q, re_st_err_d;

    logic elig_cu, elig_re, grant_cu, grant_re, out_free, acc_cu, acc_re;
    logic st_cu_hit, st_re_hit, dec_cu, dec_re;

    always_comb begin
        elig_cu  = s_axis_cu_rd_desc.valid && (cu_cnt_q < MAX_CNT);
        elig_re  = s_axis_re_rd_desc.valid && (re_cnt_q < MAX_CNT);
        grant_cu = elig_cu && (!elig_re || last_re_q);
        grant_re = elig_re && !grant_cu;
        // The single output slot can be refilled in the cycle it drains.
        out_free = !m_valid_q || m_axis_dma_read_desc.ready;
        acc_cu   = out_free && grant_cu;
        acc_re   = out_free && grant_re;

        st_cu_hit = s_axis_dma_read_desc_status_valid &&
                    !s_axis_dma_read_desc_status_tag[DMA_TAG_WIDTH-1];
        st_re_hit = s_axis_dma_read_desc_status_valid &&
                    s_axis_dma_read_desc_status_tag[DMA_TAG_WIDTH-1];
        dec_cu    = st_cu_hit && (cu_cnt_q != 8'd0);
        dec_re    = st_re_hit && (re_cnt_q != 8'd0);

        last_re_d    = last_re_q;
        m_valid_d    = m_valid_q;
        m_src_d      = m_src_q;
        m_dma_addr_d = m_dma_addr_q;
        m_ram_addr_d = m_ram_addr_q;
        m_len_d      = m_len_q;
        m_src_tag_d  = m_src_tag_q;

        if (out_free) begin
            m_valid_d = acc_cu || acc_re;
        end
        if (acc_cu) begin
            last_re_d    = 1'b0;
            m_src_d      = 1'b0;
            m_dma_addr_d = s_axis_cu_rd_desc.dma_addr;
            m_ram_addr_d = s_axis_cu_rd_desc.ram_addr;
            m_len_d      = s_axis_cu_rd_desc.len;
            m_src_tag_d  = s_axis_cu_rd_desc.tag;
        end else if (acc_re) begin
            last_re_d    = 1'b1;
            m_src_d      = 1'b1;
            m_dma_addr_d = s_axis_re_rd_desc.dma_addr;
            m_ram_addr_d = s_axis_re_rd_desc.ram_addr;
            m_len_d      = s_axis_re_rd_desc.len;
            m_src_tag_d  = s_axis_re_rd_desc.tag;
        end

        cu_cnt_d = cu_cnt_q;
        case ({acc_cu, dec_cu})
            2'b10:   cu_cnt_d = cu_cnt_q + 8'd1;
            2'b01:   cu_cnt_d = cu_cnt_q - 8'd1;
            default: cu_cnt_d = cu_cnt_q;
        endcase
        re_cnt_d = re_cnt_q;
        case ({acc_re, dec_re})
            2'b10:   re_cnt_d = re_cnt_q + 8'd1;
            2'b01:   re_cnt_d = re_cnt_q - 8'd1;
            default: re_cnt_d = re_cnt_q;
        endcase

        underflow_d = underflow_q || (st_cu_hit && (cu_cnt_q == 8'd0)) ||
                      (st_re_hit && (re_cnt_q == 8'd0));

        cu_st_valid_d = st_cu_hit;
        cu_st_tag_d   = cu_st_tag_q;
        cu_st_err_d   = cu_st_err_q;
        re_st_valid_d = st_re_hit;
        re_st_tag_d   = re_st_tag_q;
        re_st_err_d   = re_st_err_q;
        if (st_cu_hit) begin
            cu_st_tag_d = s_axis_dma_read_desc_status_tag[SRC_TAG_WIDTH-1:0];
            cu_st_err_d = s_axis_dma_read_desc_status_error;
        end
        if (st_re_hit) begin
            re_st_tag_d = s_axis_dma_read_desc_status_tag[SRC_TAG_WIDTH-1:0];
            re_st_err_d = s_axis_dma_read_desc_status_error;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_re_q     <= 1'b1;
            m_valid_q     <= 1'b0;
            m_src_q       <= 1'b0;
            m_dma_addr_q  <= '0;
            m_ram_addr_q  <= '0;
            m_len_q       <= '0;
            m_src_tag_q   <= '0;
            cu_cnt_q      <= 8'd0;
            re_cnt_q      <= 8'd0;
            underflow_q   <= 1'b0;
            cu_st_valid_q <= 1'b0;
            cu_st_tag_q   <= '0;
            cu_st_err_q   <= 4'd0;
            re_st_valid_q <= 1'b0;
            re_st_tag_q   <= '0;
            re_st_err_q   <= 4'd0;
        end else begin
            last_re_q     <= last_re_d;
            m_valid_q     <= m_valid_d;
            m_src_q       <= m_src_d;
            m_dma_addr_q  <= m_dma_addr_d;
            m_ram_addr_q  <= m_ram_addr_d;
            m_len_q       <= m_len_d;
            m_src_tag_q   <= m_src_tag_d;
            cu_cnt_q      <= cu_cnt_d;
            re_cnt_q      <= re_cnt_d;
            underflow_q   <= underflow_d;
            cu_st_valid_q <= cu_st_valid_d;
            cu_st_tag_q   <= cu_st_tag_d;
            cu_st_err_q   <= cu_st_err_d;
            re_st_valid_q <= re_st_valid_d;
            re_st_tag_q   <= re_st_tag_d;
            re_st_err_q   <= re_st_err_d;
        end
    end

    assign s_axis_cu_rd_desc.ready     = acc_cu;
    assign s_axis_re_rd_desc.ready     = acc_re;
    assign m_axis_dma_read_desc.dma_addr = m_dma_addr_q;
    assign m_axis_dma_read_desc.ram_addr = m_ram_addr_q;
    assign m_axis_dma_read_desc.len      = m_len_q;
    assign m_axis_dma_read_desc.tag      = {m_src_q, m_src_tag_q};
    assign m_axis_dma_read_desc.valid    = m_valid_q;
    assign m_axis_dma_read_wqe_tag     = m_src_q;
    assign m_axis_dma_read_wqe_valid   = m_valid_q;
    assign m_axis_dma_read_wqe_ready   = m_axis_dma_read_desc.ready;

    assign m_axis_cu_rd_desc_status_tag   = cu_st_tag_q;
    assign m_axis_cu_rd_desc_status_error = cu_st_err_q;
    assign m_axis_cu_rd_desc_status_valid = cu_st_valid_q;
    assign m_axis_re_rd_desc_status_tag   = re_st_tag_q;
    assign m_axis_re_rd_desc_status_error = re_st_err_q;
    assign m_axis_re_rd_desc_status_valid = re_st_valid_q;
    assign cu_outstanding   = cu_cnt_q;
    assign re_outstanding   = re_cnt_q;
    assign status_underflow = underflow_q;
endmodule

// File: tb/tb_dma_rd_desc_arb.sv
// Directed bench for dma_rd_desc_arb: CU-only issue, round-robin
// alternation, output stall, outstanding limit, status routing, underflow
// flag and asynchronous reset mid-transfer.
module tb_dma_rd_desc_arb;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] st_tag = 8'h00;
    logic [3:0] st_err = 4'h0;
    logic       st_valid = 1'b0;
    logic       wqe_tag, wqe_valid, wqe_ready;
    logic [6:0] cu_st_tag, re_st_tag;
    logic [3:0] cu_st_err, re_st_err;
    logic       cu_st_valid, re_st_valid;
    logic [7:0] cu_out, re_out;
    logic       underflow;

    int n_cmp = 0;
    int n_bad = 0;

    dma_rd_desc_arb_if #(.TAG_WIDTH(7)) cu_if ();
    dma_rd_desc_arb_if #(.TAG_WIDTH(7)) re_if ();
    dma_rd_desc_arb_if #(.TAG_WIDTH(8)) m_if ();

    always #5 clk = ~clk;

    dma_rd_desc_arb dut (
        .clk                               (clk),
        .rst                               (rst),
        .s_axis_cu_rd_desc                 (cu_if),
        .s_axis_re_rd_desc                 (re_if),
        .m_axis_dma_read_desc              (m_if),
        .m_axis_dma_read_wqe_tag           (wqe_tag),
        .m_axis_dma_read_wqe_valid         (wqe_valid),
        .m_axis_dma_read_wqe_ready         (wqe_ready),
        .s_axis_dma_read_desc_status_tag   (st_tag),
        .s_axis_dma_read_desc_status_error (st_err),
        .s_axis_dma_read_desc_status_valid (st_valid),
        .m_axis_cu_rd_desc_status_tag      (cu_st_tag),
        .m_axis_cu_rd_desc_status_error    (cu_st_err),
        .m_axis_cu_rd_desc_status_valid    (cu_st_valid),
        .m_axis_re_rd_desc_status_tag      (re_st_tag),
        .m_axis_re_rd_desc_status_error    (re_st_err),
        .m_axis_re_rd_desc_status_valid    (re_st_valid),
        .cu_outstanding                    (cu_out),
        .re_outstanding                    (re_out),
        .status_underflow                  (underflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    task automatic drive_cu(input logic v, input logic [6:0] t);
        cu_if.valid    = v;
        cu_if.tag      = t;
        cu_if.dma_addr = 64'hC000_0000_0000_0000 | 64'(t);
        cu_if.ram_addr = 15'h100 + 15'(t);
        cu_if.len      = 16'd64 + 16'(t);
    endtask

    task automatic drive_re(input logic v, input logic [6:0] t);
        re_if.valid    = v;
        re_if.tag      = t;
        re_if.dma_addr = 64'hE000_0000_0000_0000 | 64'(t);
        re_if.ram_addr = 15'h200 + 15'(t);
        re_if.len      = 16'd128 + 16'(t);
    endtask

    task automatic send_status(input logic [7:0] t, input logic [3:0] e);
        st_tag   = t;
        st_err   = e;
        st_valid = 1'b1;
        tick();
        st_valid = 1'b0;
    endtask

    initial begin
        drive_cu(1'b0, 7'h00);
        drive_re(1'b0, 7'h00);
        m_if.ready = 1'b1;

        // reset state
        tick();
        tick();
        check("rst_m_valid", m_if.valid, 0);
        check("rst_cu_out", cu_out, 0);
        check("rst_re_out", re_out, 0);
        check("rst_underflow", underflow, 0);
        check("rst_cu_st_valid", cu_st_valid, 0);
        check("rst_re_st_valid", re_st_valid, 0);
        rst = 1'b1;
        tick();

        // CU only, three back-to-back descriptors
        drive_cu(1'b1, 7'h01);
        #1;
        check("t1_cu_ready", cu_if.ready, 1);
        check("t1_re_ready", re_if.ready, 0);
        tick();
        check("t1_m_valid", m_if.valid, 1);
        check("t1_tag1", m_if.tag, 8'h01);
        check("t1_dma_addr", m_if.dma_addr, 64'hC000_0000_0000_0001);
        check("t1_ram_addr", m_if.ram_addr, 15'h101);
        check("t1_len", m_if.len, 16'd65);
        check("t1_wqe_tag1", wqe_tag, 0);
        check("t1_wqe_valid", wqe_valid, 1);
        check("t1_cu_out1", cu_out, 1);
        drive_cu(1'b1, 7'h02);
        tick();
        check("t1_tag2", m_if.tag, 8'h02);
        check("t1_wqe_tag2", wqe_tag, 0);
        drive_cu(1'b1, 7'h03);
        tick();
        check("t1_tag3", m_if.tag, 8'h03);
        check("t1_wqe_tag3", wqe_tag, 0);
        check("t1_cu_out3", cu_out, 3);
        drive_cu(1'b0, 7'h00);
        tick();
        check("t1_m_idle", m_if.valid, 0);
        check("t1_cu_out_hold", cu_out, 3);

        // one RE descriptor so CU is favoured next
        drive_re(1'b1, 7'h10);
        tick();
        check("t2_re_tag", m_if.tag, 8'h90);
        check("t2_re_wqe", wqe_tag, 1);
        check("t2_re_ram", m_if.ram_addr, 15'h210);
        check("t2_re_out1", re_out, 1);

        // both valid: CU, RE, CU, RE
        drive_cu(1'b1, 7'h21);
        drive_re(1'b1, 7'h31);
        #1;
        check("t2_cu_ready_a", cu_if.ready, 1);
        check("t2_re_ready_a", re_if.ready, 0);
        tick();
        check("t2_g0_tag", m_if.tag, 8'h21);
        check("t2_g0_wqe", wqe_tag, 0);
        drive_cu(1'b1, 7'h22);
        #1;
        check("t2_cu_ready_b", cu_if.ready, 0);
        check("t2_re_ready_b", re_if.ready, 1);
        tick();
        check("t2_g1_tag", m_if.tag, 8'hB1);
        check("t2_g1_wqe", wqe_tag, 1);
        drive_re(1'b1, 7'h32);
        tick();
        check("t2_g2_tag", m_if.tag, 8'h22);
        check("t2_g2_wqe", wqe_tag, 0);
        drive_cu(1'b0, 7'h00);
        tick();
        check("t2_g3_tag", m_if.tag, 8'hB2);
        check("t2_g3_wqe", wqe_tag, 1);
        drive_re(1'b0, 7'h00);
        tick();
        check("t2_m_idle", m_if.valid, 0);
        check("t2_cu_out", cu_out, 5);
        check("t2_re_out", re_out, 3);

        // output stall for 5 cycles
        m_if.ready = 1'b0;
        drive_cu(1'b1, 7'h40);
        tick();
        check("t3_m_valid", m_if.valid, 1);
        check("t3_tag", m_if.tag, 8'h40);
        drive_cu(1'b1, 7'h41);
        drive_re(1'b1, 7'h33);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t3_hold_valid", m_if.valid, 1);
            check("t3_hold_tag", m_if.tag, 8'h40);
            check("t3_hold_addr", m_if.dma_addr, 64'hC000_0000_0000_0040);
            check("t3_hold_len", m_if.len, 16'd128);
            check("t3_cu_ready", cu_if.ready, 0);
            check("t3_re_ready", re_if.ready, 0);
            check("t3_cu_out", cu_out, 6);
            check("t3_re_out", re_out, 3);
            check("t3_wqe_ready", wqe_ready, 0);
            tick();
        end
        drive_cu(1'b0, 7'h00);
        drive_re(1'b0, 7'h00);
        m_if.ready = 1'b1;
        #1;
        check("t3_wqe_ready_rel", wqe_ready, 1);
        tick();
        check("t3_released_once", m_if.valid, 0);
        check("t3_cu_out_rel", cu_out, 6);
        check("t3_re_out_rel", re_out, 3);

        // fill CU to the limit, RE still passes
        for (int i = 0; i < 10; i++) begin
            drive_cu(1'b1, 7'(8'h50 + i));
            tick();
        end
        check("t4_cu_out16", cu_out, 16);
        check("t4_last_cu_tag", m_if.tag, 8'h59);
        drive_cu(1'b1, 7'h5A);
        #1;
        check("t4_cu_blocked", cu_if.ready, 0);
        drive_re(1'b1, 7'h34);
        #1;
        check("t4_re_ready", re_if.ready, 1);
        tick();
        check("t4_re_tag", m_if.tag, 8'hB4);
        check("t4_re_out4", re_out, 4);
        check("t4_cu_out_still16", cu_out, 16);
        drive_re(1'b0, 7'h00);
        #1;
        check("t4_cu_still_blocked", cu_if.ready, 0);
        send_status(8'h05, 4'h0);
        #1;
        check("t4_cu_out15", cu_out, 15);
        check("t4_cu_reenabled", cu_if.ready, 1);
        check("t4_cu_st_valid", cu_st_valid, 1);
        check("t4_cu_st_tag", cu_st_tag, 7'h05);
        check("t4_re_st_quiet", re_st_valid, 0);
        tick();
        check("t4_cu_tag_after", m_if.tag, 8'h5A);
        check("t4_cu_out_back16", cu_out, 16);
        check("t4_cu_st_pulse", cu_st_valid, 0);
        drive_cu(1'b0, 7'h00);
        tick();

        // status routed to RE
        send_status(8'h83, 4'h2);
        #1;
        check("t5_re_st_valid", re_st_valid, 1);
        check("t5_re_st_tag", re_st_tag, 7'h03);
        check("t5_re_st_err", re_st_err, 4'h2);
        check("t5_cu_st_valid", cu_st_valid, 0);
        check("t5_re_out3", re_out, 3);
        tick();
        check("t5_re_st_pulse", re_st_valid, 0);

        // drain RE, then underflow
        for (int i = 0; i < 3; i++) send_status(8'h80, 4'h0);
        #1;
        check("t6_re_out0", re_out, 0);
        check("t6_no_underflow", underflow, 0);
        send_status(8'h81, 4'h0);
        #1;
        check("t6_underflow", underflow, 1);
        check("t6_re_out_held", re_out, 0);
        check("t6_cu_out_held", cu_out, 16);
        tick();
        tick();
        check("t6_underflow_sticky", underflow, 1);

        // asynchronous reset with a descriptor stuck in the output register
        m_if.ready = 1'b0;
        drive_re(1'b1, 7'h35);
        #1;
        check("t7_re_ready", re_if.ready, 1);
        tick();
        check("t7_m_valid", m_if.valid, 1);
        check("t7_tag", m_if.tag, 8'hB5);
        check("t7_re_out1", re_out, 1);
        drive_re(1'b0, 7'h00);
        #2;
        rst = 1'b0;
        #1;
        check("t7_rst_m_valid", m_if.valid, 0);
        check("t7_rst_wqe_valid", wqe_valid, 0);
        check("t7_rst_cu_out", cu_out, 0);
        check("t7_rst_re_out", re_out, 0);
        check("t7_rst_underflow", underflow, 0);
        m_if.ready = 1'b1;
        tick();
        rst = 1'b1;
        tick();

        // after reset CU is favoured first
        drive_cu(1'b1, 7'h61);
        drive_re(1'b1, 7'h71);
        #1;
        check("t7_post_cu_ready", cu_if.ready, 1);
        check("t7_post_re_ready", re_if.ready, 0);
        tick();
        check("t7_post_tag", m_if.tag, 8'h61);
        drive_cu(1'b0, 7'h00);
        tick();
        check("t7_post_re_tag", m_if.tag, 8'hF1);
        drive_re(1'b0, 7'h00);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dma_rd_desc_arb.md
Name: dma_rd_desc_arb

Overview:
- Upstream stage of the DMA write-data demux.
- Arbitrates DMA read descriptors from two sources, CU (index 0) and RE (index 1), onto a single DMA read descriptor channel.
- Stamps each granted descriptor with a 1-bit source tag, exported on the wqe_tag stream that the demux's tag FIFO consumes.
- Routes DMA read completion status back to the issuing source and enforces a per-source outstanding-request limit.

Parameters:
- DMA_ADDR_WIDTH, 64, host DMA address width
- RAM_ADDR_WIDTH, 15, on-chip RAM address width ($clog2(32768))
- DMA_LEN_WIDTH, 16, transfer length width in bytes
- SRC_TAG_WIDTH, 7, per-source tag width
- DMA_TAG_WIDTH, SRC_TAG_WIDTH+1, outgoing tag width; MSB is the source bit
- MAX_OUTSTANDING, 16, per-source in-flight limit (1..255)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- s_axis_cu_rd_desc_dma_addr  in  DMA_ADDR_WIDTH  CU host address
- s_axis_cu_rd_desc_ram_addr  in  RAM_ADDR_WIDTH  CU RAM address
- s_axis_cu_rd_desc_len  in  DMA_LEN_WIDTH  CU length
- s_axis_cu_rd_desc_tag  in  SRC_TAG_WIDTH  CU tag
- s_axis_cu_rd_desc_valid / _ready  in / out  1  CU handshake
- s_axis_re_rd_desc_*  same set of fields and handshake for RE
- m_axis_dma_read_desc_dma_addr / _ram_addr / _len  out  as above  merged descriptor
- m_axis_dma_read_desc_tag  out  DMA_TAG_WIDTH  {src, src_tag}
- m_axis_dma_read_desc_valid  out  1  descriptor valid
- m_axis_dma_read_desc_ready  in  1  descriptor ready
- m_axis_dma_read_wqe_tag  out  1  src bit of the presented descriptor (0=CU, 1=RE)
- m_axis_dma_read_wqe_valid  out  1  equals m_axis_dma_read_desc_valid
- m_axis_dma_read_wqe_ready  out  1  equals m_axis_dma_read_desc_ready
- s_axis_dma_read_desc_status_tag  in  DMA_TAG_WIDTH  completion tag
- s_axis_dma_read_desc_status_error  in  4  completion error code
- s_axis_dma_read_desc_status_valid  in  1  completion strobe (no backpressure)
- m_axis_cu_rd_desc_status_tag / _error / _valid  out  SRC_TAG_WIDTH / 4 / 1  CU completion
- m_axis_re_rd_desc_status_tag / _error / _valid  out  same widths  RE completion
- cu_outstanding, re_outstanding  out  8  in-flight counts
- status_underflow  out  1  sticky: status received for a source with count 0

Behaviour:
- Reset (rst low, asynchronous):
  - All valids 0; counts 0; status_underflow 0.
  - Round-robin pointer favours CU first.
  - Descriptor and status registers 0.
- Output register: one entry.
  - It is free when empty, or when it is being consumed this cycle (valid&&ready).
  - s_axis_x_ready = register free && grant_x.
  - Latency from source valid to m valid: 1 cycle.
  - Full throughput: one descriptor per cycle.
- Eligibility: a source is eligible when its valid is high and its count < MAX_OUTSTANDING.
- Round-robin arbitration:
  - If both sources are eligible, grant the one not granted last.
  - If only one is eligible, grant it.
  - The pointer updates only on an accepted grant.
- Output stability: while m valid && !ready, all m fields are held stable.
- Tag formation: m tag = {src, src_tag}; wqe_tag = src.
- Outstanding counters:
  - Count increments on the source handshake.
  - Count decrements on status_valid whose tag MSB selects that source.
  - Simultaneous increment and decrement on the same source leaves the count unchanged.
  - A count equal to MAX_OUTSTANDING blocks that source only; the other source continues.
  - A decrement at count 0 is ignored and sets status_underflow. It clears only on reset.
- Status routing:
  - Registered, 1-cycle latency.
  - The tag MSB selects the CU or RE output; lower bits form the src tag; error passes through.
  - The non-selected output valid stays 0.
- Reset mid-operation: an in-flight descriptor in the output register is discarded; counts clear to 0.

Test Plan:
- CU only, three descriptors (tags 1,2,3), m ready held high.
  - Expect m tags 0x01,0x02,0x03 on consecutive cycles.
  - Expect wqe_tag 0 each time; cu_outstanding reaches 3.
- CU and RE valid together for 4 cycles.
  - Expect grants alternating CU,RE,CU,RE.
  - Expect wqe_tag 0,1,0,1; m tags carry MSB accordingly.
- m ready low for 5 cycles with a descriptor pending.
  - Expect the m fields stable and both s ready signals 0.
  - Expect no counter change; on release the descriptor transfers once.
- Issue 16 CU descriptors without status.
  - Expect CU ready to drop with cu_outstanding=16 while RE descriptors still pass.
  - One status with tag 0x05 makes cu_outstanding 15 and re-enables CU.
- Status tag 0x83 with error 0x2.
  - Expect m_axis_re_rd_desc_status_tag=0x03, error 0x2, valid one cycle later.
  - Expect the CU status valid to stay 0.
- Status for RE while re_outstanding=0.
  - Expect status_underflow=1 and sticky; counts unchanged.
  - Assert rst low mid-transfer: m valid drops immediately; counts and the flag clear.
